// File: rtl/tubes_scheduler.sv
// ---------------------------------------------------------------------------
// tubes_scheduler
//
// Owns the eight 8-bit character slots feeding the seven-segment display
// driver. Three requesters share the slots:
//   * timed alerts    - captured on request, held for HOLD_TICKS ticks
//   * status text     - shown live for as long as status_valid is high
//   * scroll banner   - 16-char ring, advanced one char every SCROLL_TICKS ticks
// Priority is alert > status > scroll > blank. Code 8'hFF is blank.
//
// Parameters
//   TICK_DIV      clk cycles per scheduler tick (>=2)
//   HOLD_TICKS    ticks an accepted alert stays on screen (>=1)
//   SCROLL_TICKS  ticks between one-char scroll steps (>=1)
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   alert_req         level request, alert_text valid while high
//   alert_text[63:0]  8 chars, [63:56] -> data7 ... [7:0] -> data0
//   alert_ack         one-cycle pulse when alert_text has been captured
//   status_valid      level; status_text shown while high (no alert active)
//   status_text[63:0] same packing as alert_text, sampled every cycle
//   scroll_en         level; enables the scrolling banner
//   scroll_text[127:0] 16 chars, [127:120]=char0 ... [7:0]=char15
//   data7..data0      registered char codes to the display driver
//   src[1:0]          registered source: 0 blank, 1 scroll, 2 status, 3 alert
// ---------------------------------------------------------------------------
module tubes_scheduler #(
  parameter int unsigned TICK_DIV     = 10_000_000,
  parameter int unsigned HOLD_TICKS   = 20,
  parameter int unsigned SCROLL_TICKS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alert_req,
  input  logic [63:0]  alert_text,
  output logic         alert_ack,
  input  logic         status_valid,
  input  logic [63:0]  status_text,
  input  logic         scroll_en,
  input  logic [127:0] scroll_text,
  output logic [7:0]   data7,
  output logic [7:0]   data6,
  output logic [7:0]   data5,
  output logic [7:0]   data4,
  output logic [7:0]   data3,
  output logic [7:0]   data2,
  output logic [7:0]   data1,
  output logic [7:0]   data0,
  output logic [1:0]   src
);

  // -------------------------------------------------------------------------
  // Widths and constants
  // -------------------------------------------------------------------------
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int unsigned STEP_W = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SCROLL_TICKS - 1);
  localparam logic [63:0]       BLANK_ROW = {8{8'hFF}};

  // State encoding doubles as the src code presented to the driver.
  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SCROLL = 2'd1,
    ST_STATUS = 2'd2,
    ST_ALERT  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Registers and next-state signals
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;

  state_t            state_q, state_d;
  state_t            rest_state;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        pos_q, pos_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [63:0]       alert_buf_q, alert_buf_d;
  logic [63:0]       data_q, data_d;
  logic [1:0]        src_q;
  logic              ack_q;
  logic              capture;

  logic [7:0]        scroll_chars [16];
  logic [63:0]       scroll_window;

  // -------------------------------------------------------------------------
  // Free-running tick divider: never paused, only cleared by rst, so an alert
  // may begin anywhere inside a tick period.
  // -------------------------------------------------------------------------
  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Scroll text unpacking and 8-char window starting at the next position.
  // The 4-bit index add wraps the window around the 16-char ring for free.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_chars
      assign scroll_chars[gi] = scroll_text[127 - 8*gi -: 8];
    end

    for (gi = 0; gi < 8; gi++) begin : g_window
      logic [3:0] char_idx;
      assign char_idx = pos_d + 4'(gi);
      assign scroll_window[63 - 8*gi -: 8] = scroll_chars[char_idx];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  // The ack from the previous cycle masks the request, so a requester that
  // keeps alert_req high is re-captured every other cycle.
  assign capture = alert_req && !ack_q;

  // Where the screen goes when no alert owns it.
  always_comb begin
    if (status_valid) begin
      rest_state = ST_STATUS;
    end else if (scroll_en) begin
      rest_state = ST_SCROLL;
    end else begin
      rest_state = ST_BLANK;
    end
  end

  always_comb begin
    state_d     = rest_state;
    hold_d      = hold_q;
    alert_buf_d = alert_buf_q;

    if (capture) begin
      // A fresh capture always wins, including on the tick that would
      // otherwise have ended the current alert.
      state_d     = ST_ALERT;
      hold_d      = HOLD_LOAD;
      alert_buf_d = alert_text;
    end else if (state_q == ST_ALERT) begin
      state_d = ST_ALERT;
      if (tick) begin
        if (hold_q <= HOLD_ONE) begin
          // Last tick of the hold: leave in the same cycle.
          hold_d  = '0;
          state_d = rest_state;
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scroll position: restarts at 0 on every entry into SCROLL (also after
  // being pre-empted) and is frozen while another source owns the screen.
  // -------------------------------------------------------------------------
  always_comb begin
    pos_d  = pos_q;
    step_d = step_q;
    if (state_d == ST_SCROLL) begin
      if (state_q != ST_SCROLL) begin
        pos_d  = '0;
        step_d = '0;
      end else if (tick) begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          pos_d  = pos_q + 4'd1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Display row for the state being entered.
  // -------------------------------------------------------------------------
  always_comb begin
    data_d = BLANK_ROW;
    case (state_d)
      ST_ALERT:  data_d = alert_buf_d;
      ST_STATUS: data_d = status_text;
      ST_SCROLL: data_d = scroll_window;
      default:   data_d = BLANK_ROW;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM state and registered outputs. An asynchronous reset mid-alert drops
  // the captured alert and any pending ack immediately.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      hold_q      <= '0;
      pos_q       <= '0;
      step_q      <= '0;
      alert_buf_q <= BLANK_ROW;
      data_q      <= BLANK_ROW;
      src_q       <= 2'd0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      pos_q       <= pos_d;
      step_q      <= step_d;
      alert_buf_q <= alert_buf_d;
      data_q      <= data_d;
      src_q       <= state_d;
      ack_q       <= capture;
    end
  end

  assign alert_ack = ack_q;
  assign src       = src_q;
  assign data7     = data_q[63:56];
  assign data6     = data_q[55:48];
  assign data5     = data_q[47:40];
  assign data4     = data_q[39:32];
  assign data3     = data_q[31:24];
  assign data2     = data_q[23:16];
  assign data1     = data_q[15:8];
  assign data0     = data_q[7:0];

endmodule
